xgmii_rx_align: RTL and testbench

Parametrised XGMII receive lane aligner and frame monitor for the 64-bit 10GbE RX path, sitting between the PCS/PHY XGMII output and the MAC receive logic. It rotates every frame so its /S/ (0xFB) lands in lane 0 whether the PHY delivered it in lane 0 or lane 4. It also tracks frame boundaries, reports terminate position and protocol errors in step with the aligned data, and keeps saturating or wrapping frame and error counters.

---
 rtl/xgmii_rx_align.sv | 194 +++++++++++++++++++
 tb/tb_xgmii_rx_align.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_rx_align.sv
// XGMII 64-bit receive lane aligner: rotates lane-4 starts into lane 0 and
// monitors frame boundaries, protocol errors and frame/error counts.
module xgmii_rx_align #(
  parameter int unsigned CNT_W   = 32,
  parameter bit          CNT_SAT = 1'b1
) (
  input  logic             xgmii_rx_clk,
  input  logic             sys_rst,
  input  logic [63:0]      xgmii_rxd_i,
  input  logic [7:0]       xgmii_rxc_i,
  input  logic             cnt_clr,
  output logic [63:0]      xgmii_rxd_o,
  output logic [7:0]       xgmii_rxc_o,
  output logic             sof_o,
  output logic             eof_o,
  output logic [2:0]       term_lane_o,
  output logic             err_o,
  output logic             shift_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam logic [7:0] CH_START = 8'hFB;
  localparam logic [7:0] CH_TERM  = 8'hFD;
  localparam logic [7:0] CH_ERROR = 8'hFE;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  logic [63:0]      rxd_q, rxd_d;
  logic [7:0]       rxc_q, rxc_d;
  logic             shift_q, shift_d;
  state_t           state_q, state_d;
  logic             bad_q, bad_d;
  logic             clean_q, clean_d;
  logic [63:0]      rxd_o_q, rxd_o_d;
  logic [7:0]       rxc_o_q, rxc_o_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic [2:0]       term_q, term_d;
  logic             err_q, err_d;
  logic             shift_o_q, shift_o_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [63:0] aw;
  logic [7:0]  ac;
  logic        s_det, t_det, e_det;
  logic [2:0]  t_lane;

  function automatic logic [CNT_W-1:0] cnt_bump(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] nxt;
    if (&cnt) nxt = CNT_SAT ? cnt : '0;
    else      nxt = cnt + CNT_W'(1);
    return nxt;
  endfunction

  always_comb begin
    rxd_d = xgmii_rxd_i;
    rxc_d = xgmii_rxc_i;

    // A lane-4 start outranks a lane-0 start seen in the same raw word.
    shift_d = shift_q;
    if (xgmii_rxc_i[4] && xgmii_rxd_i[39:32] == CH_START)    shift_d = 1'b1;
    else if (xgmii_rxc_i[0] && xgmii_rxd_i[7:0] == CH_START) shift_d = 1'b0;

    aw = shift_q ? {xgmii_rxd_i[31:0], rxd_q[63:32]} : rxd_q;
    ac = shift_q ? {xgmii_rxc_i[3:0], rxc_q[7:4]}    : rxc_q;

    s_det  = ac[0] && (aw[7:0] == CH_START);
    t_det  = 1'b0;
    e_det  = 1'b0;
    t_lane = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (ac[i] && aw[8*i +: 8] == CH_TERM) begin
        t_det  = 1'b1;
        t_lane = 3'(i);
      end
      if (ac[i] && aw[8*i +: 8] == CH_ERROR) e_det = 1'b1;
    end

    state_d = state_q;
    bad_d   = bad_q;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    term_d  = 3'd0;
    err_d   = e_det;
    clean_d = 1'b0;

    // A start always opens a fresh frame; a terminate in that same word is a runt.
    case (state_q)
      ST_IDLE: begin
        if (s_det) begin
          sof_d = 1'b1;
          bad_d = 1'b0;
          if (t_det) begin
            eof_d  = 1'b1;
            term_d = t_lane;
            err_d  = 1'b1;
          end else begin
            state_d = ST_FRAME;
            bad_d   = e_det;
          end
        end else if (t_det) begin
          err_d = 1'b1;
        end
      end
      ST_FRAME: begin
        if (s_det) begin
          sof_d = 1'b1;
          err_d = 1'b1;
          bad_d = e_det;
          if (t_det) begin
            eof_d   = 1'b1;
            term_d  = t_lane;
            state_d = ST_IDLE;
          end
        end else if (t_det) begin
          eof_d   = 1'b1;
          term_d  = t_lane;
          state_d = ST_IDLE;
          clean_d = !bad_q && !e_det;
        end else begin
          bad_d = bad_q | e_det;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rxd_o_d   = aw;
    rxc_o_d   = ac;
    shift_o_d = shift_q;

    // Counters trail the status word by one cycle; a clear drops that cycle's events.
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (cnt_clr) begin
      frame_cnt_d = '0;
      err_cnt_d   = '0;
    end else begin
      if (clean_q) frame_cnt_d = cnt_bump(frame_cnt_q);
      if (err_q)   err_cnt_d   = cnt_bump(err_cnt_q);
    end
  end

  always_ff @(posedge xgmii_rx_clk) begin
    if (sys_rst) begin
      rxd_q       <= '0;
      rxc_q       <= '0;
      shift_q     <= 1'b0;
      state_q     <= ST_IDLE;
      bad_q       <= 1'b0;
      clean_q     <= 1'b0;
      rxd_o_q     <= '0;
      rxc_o_q     <= '0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      term_q      <= 3'd0;
      err_q       <= 1'b0;
      shift_o_q   <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      rxd_q       <= rxd_d;
      rxc_q       <= rxc_d;
      shift_q     <= shift_d;
      state_q     <= state_d;
      bad_q       <= bad_d;
      clean_q     <= clean_d;
      rxd_o_q     <= rxd_o_d;
      rxc_o_q     <= rxc_o_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      term_q      <= term_d;
      err_q       <= err_d;
      shift_o_q   <= shift_o_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign xgmii_rxd_o = rxd_o_q;
  assign xgmii_rxc_o = rxc_o_q;
  assign sof_o       = sof_q;
  assign eof_o       = eof_q;
  assign term_lane_o = term_q;
  assign err_o       = err_q;
  assign shift_o     = shift_o_q;
  assign frame_cnt_o = frame_cnt_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_xgmii_rx_align.sv
// Directed bench for xgmii_rx_align: a saturating and a wrapping 8-bit-counter
// instance share one input stream; outputs are logged per cycle and checked.
module tb_xgmii_rx_align;

  localparam int LOG_N = 1024;
  localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
  localparam logic [7:0]  IDLE_C  = 8'hFF;
  localparam logic [63:0] PRE_D   = 64'hD5555555555555FB;
  localparam logic [7:0]  PRE_C   = 8'h01;
  localparam logic [63:0] TERM0_D = 64'h07070707070707FD;
  localparam logic [7:0]  TERM0_C = 8'hFF;
  localparam logic [63:0] S4_D    = 64'h555555FB07070707;
  localparam logic [7:0]  S4_C    = 8'h1F;

  logic        xgmii_rx_clk = 1'b0;
  logic        sys_rst      = 1'b1;
  logic [63:0] xgmii_rxd_i  = 64'h0707070707070707;
  logic [7:0]  xgmii_rxc_i  = 8'hFF;
  logic        cnt_clr      = 1'b0;

  logic [63:0] s_rxd, w_rxd;
  logic [7:0]  s_rxc, w_rxc;
  logic        s_sof, s_eof, s_err, s_shift, w_sof, w_eof, w_err, w_shift;
  logic [2:0]  s_term, w_term;
  logic [7:0]  s_fcnt, s_ecnt, w_fcnt, w_ecnt;

  always #5 xgmii_rx_clk = ~xgmii_rx_clk;

  xgmii_rx_align #(.CNT_W(8), .CNT_SAT(1'b1)) dut_sat (
    .xgmii_rx_clk(xgmii_rx_clk), .sys_rst(sys_rst),
    .xgmii_rxd_i(xgmii_rxd_i), .xgmii_rxc_i(xgmii_rxc_i), .cnt_clr(cnt_clr),
    .xgmii_rxd_o(s_rxd), .xgmii_rxc_o(s_rxc), .sof_o(s_sof), .eof_o(s_eof),
    .term_lane_o(s_term), .err_o(s_err), .shift_o(s_shift),
    .frame_cnt_o(s_fcnt), .err_cnt_o(s_ecnt)
  );

  xgmii_rx_align #(.CNT_W(8), .CNT_SAT(1'b0)) dut_wrap (
    .xgmii_rx_clk(xgmii_rx_clk), .sys_rst(sys_rst),
    .xgmii_rxd_i(xgmii_rxd_i), .xgmii_rxc_i(xgmii_rxc_i), .cnt_clr(cnt_clr),
    .xgmii_rxd_o(w_rxd), .xgmii_rxc_o(w_rxc), .sof_o(w_sof), .eof_o(w_eof),
    .term_lane_o(w_term), .err_o(w_err), .shift_o(w_shift),
    .frame_cnt_o(w_fcnt), .err_cnt_o(w_ecnt)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [63:0] lg_rxd   [LOG_N];
  logic [63:0] lg_rxc   [LOG_N];
  logic [63:0] lg_sof   [LOG_N];
  logic [63:0] lg_eof   [LOG_N];
  logic [63:0] lg_term  [LOG_N];
  logic [63:0] lg_err   [LOG_N];
  logic [63:0] lg_shift [LOG_N];
  logic [63:0] lg_fcnt  [LOG_N];
  logic [63:0] lg_ecnt  [LOG_N];
  logic [63:0] lg_fcntw [LOG_N];
  logic [63:0] lg_ecntw [LOG_N];

  // Log what the DUT shows just after an edge, then drive the next raw word.
  // Output for the word driven in call j is found at log index j+2.
  task automatic applyStimulus(input logic [63:0] d, input logic [7:0] c);
    @(posedge xgmii_rx_clk);
    #1;
    if (cyc < LOG_N) begin
      lg_rxd[cyc]   = s_rxd;
      lg_rxc[cyc]   = 64'(s_rxc);
      lg_sof[cyc]   = 64'(s_sof);
      lg_eof[cyc]   = 64'(s_eof);
      lg_term[cyc]  = 64'(s_term);
      lg_err[cyc]   = 64'(s_err);
      lg_shift[cyc] = 64'(s_shift);
      lg_fcnt[cyc]  = 64'(s_fcnt);
      lg_ecnt[cyc]  = 64'(s_ecnt);
      lg_fcntw[cyc] = 64'(w_fcnt);
      lg_ecntw[cyc] = 64'(w_ecnt);
    end
    xgmii_rxd_i = d;
    xgmii_rxc_i = c;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic doReset();
    sys_rst = 1'b1;
    applyStimulus(IDLE_D, IDLE_C);
    sys_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s, t, d3, w1, w2, w3, w4, s0, t0, i2, i3, i4, i6, i8, p, r, ft;

    // Reset state
    applyStimulus(IDLE_D, IDLE_C);
    applyStimulus(IDLE_D, IDLE_C);
    sys_rst = 1'b0;
    checkOutput("rst_rxd",   lg_rxd[1],   64'h0);
    checkOutput("rst_rxc",   lg_rxc[1],   64'h0);
    checkOutput("rst_sof",   lg_sof[1],   64'h0);
    checkOutput("rst_eof",   lg_eof[1],   64'h0);
    checkOutput("rst_err",   lg_err[1],   64'h0);
    checkOutput("rst_shift", lg_shift[1], 64'h0);
    checkOutput("rst_fcnt",  lg_fcnt[1],  64'h0);
    checkOutput("rst_ecnt",  lg_ecnt[1],  64'h0);

    // Lane-0 start, six data words, terminate in lane 0
    applyStimulus(IDLE_D, IDLE_C);
    applyStimulus(IDLE_D, IDLE_C);
    applyStimulus(PRE_D, PRE_C); s = cyc - 1;
    d3 = 0;
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(64'h0123456789ABCDEF + 64'(k), 8'h00);
      if (k == 3) d3 = cyc - 1;
    end
    applyStimulus(TERM0_D, TERM0_C); t = cyc - 1;
    for (int k = 0; k < 4; k++) applyStimulus(IDLE_D, IDLE_C);
    checkOutput("l0_sof_rxd",   lg_rxd[s+2],   PRE_D);
    checkOutput("l0_sof_rxc",   lg_rxc[s+2],   64'h01);
    checkOutput("l0_sof",       lg_sof[s+2],   64'h1);
    checkOutput("l0_shift",     lg_shift[s+2], 64'h0);
    checkOutput("l0_data3",     lg_rxd[d3+2],  64'h0123456789ABCDF2);
    checkOutput("l0_eof_rxd",   lg_rxd[t+2],   TERM0_D);
    checkOutput("l0_eof",       lg_eof[t+2],   64'h1);
    checkOutput("l0_term_lane", lg_term[t+2],  64'h0);
    checkOutput("l0_eof_err",   lg_err[t+2],   64'h0);
    checkOutput("l0_fcnt_lag",  lg_fcnt[t+2],  64'h0);
    checkOutput("l0_fcnt",      lg_fcnt[t+3],  64'h1);

    // Lane-4 start, terminate in raw lane 6
    doReset();
    applyStimulus(IDLE_D, IDLE_C);
    applyStimulus(S4_D, S4_C); s = cyc - 1;
    applyStimulus(64'hA3A2A1A0D5555555, 8'h00);
    applyStimulus(64'hB7B6B5B4B3B2B1B0, 8'h00);
    applyStimulus(64'h07FDC5C4C3C2C1C0, 8'hC0); w3 = cyc - 1;
    for (int k = 0; k < 4; k++) applyStimulus(IDLE_D, IDLE_C);
    checkOutput("l4_sof_rxd",   lg_rxd[s+2],   PRE_D);
    checkOutput("l4_sof_rxc",   lg_rxc[s+2],   64'h01);
    checkOutput("l4_sof",       lg_sof[s+2],   64'h1);
    checkOutput("l4_shift",     lg_shift[s+2], 64'h1);
    checkOutput("l4_eof_rxd",   lg_rxd[w3+2],  64'h0707070707FDC5C4);
    checkOutput("l4_eof_rxc",   lg_rxc[w3+2],  64'hFC);
    checkOutput("l4_eof",       lg_eof[w3+2],  64'h1);
    checkOutput("l4_term_lane", lg_term[w3+2], 64'h2);
    checkOutput("l4_err",       lg_err[w3+2],  64'h0);
    checkOutput("l4_fcnt",      lg_fcnt[w3+3], 64'h1);
    checkOutput("l4_ecnt",      lg_ecnt[w3+3], 64'h0);

    // Lane-4 frame, 12-byte IPG, then lane-0 frame
    doReset();
    applyStimulus(IDLE_D, IDLE_C);
    applyStimulus(S4_D, S4_C);
    applyStimulus(64'hA3A2A1A0D5555555, 8'h00); w1 = cyc - 1;
    applyStimulus(64'hB7B6B5B4B3B2B1B0, 8'h00); w2 = cyc - 1;
    applyStimulus(64'h07070707FDC2C1C0, 8'hF8);
    applyStimulus(IDLE_D, IDLE_C); w4 = cyc - 1;
    applyStimulus(PRE_D, PRE_C); s0 = cyc - 1;
    applyStimulus(64'h1122334455667788, 8'h00);
    applyStimulus(TERM0_D, TERM0_C); t0 = cyc - 1;
    for (int k = 0; k < 4; k++) applyStimulus(IDLE_D, IDLE_C);
    checkOutput("alt_w1_rxd",  lg_rxd[w1+2],   64'hB3B2B1B0A3A2A1A0);
    checkOutput("alt_eof_rxd", lg_rxd[w2+2],   64'hFDC2C1C0B7B6B5B4);
    checkOutput("alt_eof_rxc", lg_rxc[w2+2],   64'h80);
    checkOutput("alt_term7",   lg_term[w2+2],  64'h7);
    checkOutput("alt_ipg_err", lg_err[w4+2],   64'h0);
    checkOutput("alt_l0_rxd",  lg_rxd[s0+2],   PRE_D);
    checkOutput("alt_l0_sof",  lg_sof[s0+2],   64'h1);
    checkOutput("alt_l0_shft", lg_shift[s0+2], 64'h0);
    checkOutput("alt_l0_data", lg_rxd[s0+3],   64'h1122334455667788);
    checkOutput("alt_l0_eof",  lg_eof[t0+2],   64'h1);
    checkOutput("alt_fcnt",    lg_fcnt[t0+3],  64'h2);
    checkOutput("alt_ecnt",    lg_ecnt[t0+3],  64'h0);

    // Restart in frame, /E/ in the restarted frame, then a stray /T/ in idle
    doReset();
    applyStimulus(IDLE_D, IDLE_C);
    applyStimulus(PRE_D, PRE_C);
    applyStimulus(64'h1010101010101010, 8'h00); i2 = cyc - 1;
    applyStimulus(PRE_D, PRE_C); i3 = cyc - 1;
    applyStimulus(64'h1111111111FE1111, 8'h04); i4 = cyc - 1;
    applyStimulus(64'h2222222222222222, 8'h00);
    applyStimulus(TERM0_D, TERM0_C); i6 = cyc - 1;
    applyStimulus(IDLE_D, IDLE_C);
    applyStimulus(TERM0_D, TERM0_C); i8 = cyc - 1;
    for (int k = 0; k < 3; k++) applyStimulus(IDLE_D, IDLE_C);
    checkOutput("err_clean",    lg_err[i2+2],  64'h0);
    checkOutput("err_restart",  lg_err[i3+2],  64'h1);
    checkOutput("sof_restart",  lg_sof[i3+2],  64'h1);
    checkOutput("err_e_code",   lg_err[i4+2],  64'h1);
    checkOutput("bad_eof",      lg_eof[i6+2],  64'h1);
    checkOutput("bad_eof_err",  lg_err[i6+2],  64'h0);
    checkOutput("err_t_idle",   lg_err[i8+2],  64'h1);
    checkOutput("eof_t_idle",   lg_eof[i8+2],  64'h0);
    checkOutput("err_ecnt",     lg_ecnt[i8+3], 64'h3);
    checkOutput("err_ecnt_w",   lg_ecntw[i8+3], 64'h3);
    checkOutput("err_fcnt",     lg_fcnt[i8+3], 64'h0);

    // 260 clean frames: saturate vs wrap, then clear coincident with eof
    doReset();
    for (int k = 0; k < 260; k++) begin
      applyStimulus(PRE_D, PRE_C);
      applyStimulus(TERM0_D, TERM0_C);
    end
    applyStimulus(IDLE_D, IDLE_C);
    applyStimulus(IDLE_D, IDLE_C);
    applyStimulus(IDLE_D, IDLE_C);
    applyStimulus(IDLE_D, IDLE_C);
    checkOutput("sat_fcnt",  lg_fcnt[cyc-1],  64'd255);
    checkOutput("wrap_fcnt", lg_fcntw[cyc-1], 64'd4);
    checkOutput("sat_ecnt",  lg_ecnt[cyc-1],  64'd0);
    applyStimulus(PRE_D, PRE_C);
    applyStimulus(TERM0_D, TERM0_C); t = cyc - 1;
    applyStimulus(IDLE_D, IDLE_C);
    applyStimulus(IDLE_D, IDLE_C);
    cnt_clr = 1'b1;
    applyStimulus(IDLE_D, IDLE_C);
    cnt_clr = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(IDLE_D, IDLE_C);
    checkOutput("clr_eof",       lg_eof[t+2],   64'h1);
    checkOutput("clr_pre_sat",   lg_fcnt[t+2],  64'd255);
    checkOutput("clr_fcnt",      lg_fcnt[t+3],  64'd0);
    checkOutput("clr_fcnt_w",    lg_fcntw[t+3], 64'd0);
    checkOutput("clr_fcnt_hold", lg_fcnt[t+5],  64'd0);

    // Reset asserted for one cycle in the middle of a lane-4 frame
    doReset();
    applyStimulus(IDLE_D, IDLE_C);
    applyStimulus(PRE_D, PRE_C);
    applyStimulus(TERM0_D, TERM0_C);
    applyStimulus(IDLE_D, IDLE_C);
    applyStimulus(S4_D, S4_C); s = cyc - 1;
    applyStimulus(64'hA3A2A1A0D5555555, 8'h00);
    sys_rst = 1'b1;
    applyStimulus(IDLE_D, IDLE_C); r = cyc - 1;
    sys_rst = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(IDLE_D, IDLE_C);
    applyStimulus(PRE_D, PRE_C); p = cyc - 1;
    applyStimulus(64'h3333333333333333, 8'h00);
    applyStimulus(TERM0_D, TERM0_C); ft = cyc - 1;
    for (int k = 0; k < 4; k++) applyStimulus(IDLE_D, IDLE_C);
    checkOutput("mid_pre_fcnt",  lg_fcnt[s+1],  64'd1);
    checkOutput("mid_rst_rxd",   lg_rxd[r],     64'h0);
    checkOutput("mid_rst_rxc",   lg_rxc[r],     64'h0);
    checkOutput("mid_rst_shift", lg_shift[r],   64'h0);
    checkOutput("mid_rst_fcnt",  lg_fcnt[r],    64'h0);
    checkOutput("mid_rel_rxd",   lg_rxd[r+1],   64'h0);
    checkOutput("mid_rel_eof",   lg_eof[r+1],   64'h0);
    checkOutput("mid_rel_err",   lg_err[r+1],   64'h0);
    checkOutput("mid_new_sof",   lg_sof[p+2],   64'h1);
    checkOutput("mid_new_eof",   lg_eof[ft+2],  64'h1);
    checkOutput("mid_new_fcnt",  lg_fcnt[ft+3], 64'd1);
    checkOutput("mid_new_ecnt",  lg_ecnt[ft+3], 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
